dmem_arbiter: RTL and testbench

Shares the single data-RAM port between the core's MEM stage and the io loader/dumper. Accepts level-held read/write requests from both requesters, serializes them onto one BRAM port with fixed read latency, and returns one-cycle `data_ready_*` completions with registered read data. Sits between `exmem`/`io` and the data BRAM, replacing direct port muxing inside the RAM wrapper.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_pick.sv | 29 ++
 rtl/dmem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-RAM arbiter: FSM state encoding,
// requester ids and the default BRAM word-address width.
package dmem_arb_pkg;

    // Default BRAM word-address width (byte address bits [DMEM_ADDR_W+1:2]).
    localparam int DMEM_ADDR_W = 17;

    // Requester ids, also used as the round-robin pointer value.
    localparam logic ARB_CORE = 1'b0;
    localparam logic ARB_IO   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } dmem_arb_state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
// Combinational winner select between the core and io requesters.
// Ports:
//   i_core_pend : core has an eligible request
//   i_io_pend   : io has a request
//   i_prio      : requester that wins a tie (ARB_CORE / ARB_IO)
//   o_grant     : at least one requester is pending
//   o_winner    : selected requester id (valid when o_grant=1)
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic i_core_pend,
    input  logic i_io_pend,
    input  logic i_prio,
    output logic o_grant,
    output logic o_winner
);

    always_comb begin
        o_grant  = i_core_pend | i_io_pend;
        o_winner = ARB_CORE;
        if (i_core_pend && i_io_pend) begin
            o_winner = i_prio;
        end else if (i_io_pend) begin
            o_winner = ARB_IO;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one data BRAM port between the core MEM stage and the io
// loader/dumper. Level-held requests are serialized through an
// IDLE -> ACCESS -> (WAIT) -> DONE sequence; completion is a one-cycle
// ready pulse and read data is held in a per-requester register.
//
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking
// (core wins the first tie after reset). Without it io wins every tie.
//
// Valid/ready: a requester raises read and/or write with stable address
// and data and holds them until its data_ready_* is seen high; it may
// present the next request in the following cycle. Read+write together
// is treated as a write.
//
// Ports:
//   clk, rstn                              : clock, async active-low reset
//   memread_mem/memwrite_mem/alu_result_mem/write_data_memory_mem : core request
//   memread_io/memwrite_io/addr_io/write_data_io                  : io request
//   core_start, core_end                   : core run window (gates core grants)
//   data_ready_mem, data_ready_io          : completion / advance indications
//   data_from_memory_mem, data_from_memory_io : registered read data
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata : BRAM port
//   o_dbg_state                            : current FSM state
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              memread_mem,
    input  logic              memwrite_mem,
    input  logic [31:0]       alu_result_mem,
    input  logic [31:0]       write_data_memory_mem,
    input  logic              memread_io,
    input  logic              memwrite_io,
    input  logic [31:0]       addr_io,
    input  logic [31:0]       write_data_io,
    input  logic              core_start,
    input  logic              core_end,
    output logic              data_ready_mem,
    output logic              data_ready_io,
    output logic [31:0]       data_from_memory_mem,
    output logic [31:0]       data_from_memory_io,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [1:0]        o_dbg_state
);

    // WAIT counts down from READ_LATENCY-1 to 0; capture happens at 0.
    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

    dmem_arb_state_t   r_state;
    dmem_arb_state_t   w_next;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_wdata;
    logic [31:0]       r_rdata_mem;
    logic [31:0]       r_rdata_io;
    logic              r_winner;
    logic [1:0]        r_wait_cnt;

    logic              w_core_pend;
    logic              w_core_elig;
    logic              w_io_pend;
    logic              w_prio;
    logic              w_grant;
    logic              w_winner;
    logic              w_sel_write;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_load;
    logic              w_capture;
    logic              w_unused_addr_bits;

    assign w_core_pend = memread_mem | memwrite_mem;
    assign w_core_elig = w_core_pend & core_start & ~core_end;
    assign w_io_pend   = memread_io | memwrite_io;

`ifdef DMEM_ARB_RR_EN
    // Last granted requester; the other one gets the next tie.
    logic r_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last <= ARB_IO;
        end else if (w_load) begin
            r_last <= w_winner;
        end
    end

    assign w_prio = ~r_last;
`else
    assign w_prio = ARB_IO;
`endif

    dmem_arb_pick u_pick (
        .i_core_pend (w_core_elig),
        .i_io_pend   (w_io_pend),
        .i_prio      (w_prio),
        .o_grant     (w_grant),
        .o_winner    (w_winner)
    );

    // Winner's request fields; a write bit wins over a read bit.
    assign w_sel_write = (w_winner == ARB_IO) ? memwrite_io   : memwrite_mem;
    assign w_sel_addr  = (w_winner == ARB_IO) ? addr_io       : alu_result_mem;
    assign w_sel_wdata = (w_winner == ARB_IO) ? write_data_io : write_data_memory_mem;

    // Only the word-address bits of the byte addresses reach the BRAM.
    assign w_unused_addr_bits = ^{alu_result_mem, addr_io};

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next = ACCESS;
                    w_load = 1'b1;
                end
            end
            ACCESS: begin
                // r_ram_we still reflects this access while in ACCESS.
                w_next = r_ram_we ? DONE : WAIT;
            end
            WAIT: begin
                if (r_wait_cnt == 2'd0) begin
                    w_next    = DONE;
                    w_capture = 1'b1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rdata_mem <= '0;
            r_rdata_io  <= '0;
            r_winner    <= ARB_CORE;
            r_wait_cnt  <= '0;
        end else begin
            if (w_load) begin
                r_ram_en    <= 1'b1;
                r_ram_we    <= w_sel_write;
                r_ram_addr  <= w_sel_addr[ADDR_W+1:2];
                r_ram_wdata <= w_sel_wdata;
                r_winner    <= w_winner;
            end else if (r_state == ACCESS) begin
                r_ram_en <= 1'b0;
                r_ram_we <= 1'b0;
            end

            if (r_state == ACCESS) begin
                r_wait_cnt <= WAIT_INIT;
            end else if (r_state == WAIT && r_wait_cnt != 2'd0) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end

            if (w_capture) begin
                if (r_winner == ARB_IO) begin
                    r_rdata_io <= ram_rdata;
                end else begin
                    r_rdata_mem <= ram_rdata;
                end
            end
        end
    end

    // The core may advance whenever it is not asking for anything.
    assign data_ready_mem = ~w_core_pend | ((r_state == DONE) && (r_winner == ARB_CORE));
    assign data_ready_io  = (r_state == DONE) && (r_winner == ARB_IO);

    assign data_from_memory_mem = r_rdata_mem;
    assign data_from_memory_io  = r_rdata_io;
    assign ram_en               = r_ram_en;
    assign ram_we               = r_ram_we;
    assign ram_addr             = r_ram_addr;
    assign ram_wdata            = r_ram_wdata;
    assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: a small BRAM model with
// READ_LATENCY pipeline, a memory/ready reference model derived from the
// arbitration rules, directed scenarios and a randomized request loop.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int   L        = 1;
    localparam logic WHO_CORE = 1'b0;
    localparam logic WHO_IO   = 1'b1;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        c_rd = 1'b0, c_wr = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic        io_rd = 1'b0, io_wr = 1'b0;
    logic [31:0] io_addr = '0, io_wdata = '0;
    logic        core_start = 1'b0, core_end = 1'b0;
    logic        data_ready_mem, data_ready_io;
    logic [31:0] data_from_memory_mem, data_from_memory_io;
    logic        ram_en, ram_we;
    logic [16:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] ref_dm = '0;
    logic [31:0] ref_dio = '0;
    logic        ref_last = WHO_IO;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(17), .READ_LATENCY(L)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .memread_mem           (c_rd),
        .memwrite_mem          (c_wr),
        .alu_result_mem        (c_addr),
        .write_data_memory_mem (c_wdata),
        .memread_io            (io_rd),
        .memwrite_io           (io_wr),
        .addr_io               (io_addr),
        .write_data_io         (io_wdata),
        .core_start            (core_start),
        .core_end              (core_end),
        .data_ready_mem        (data_ready_mem),
        .data_ready_io         (data_ready_io),
        .data_from_memory_mem  (data_from_memory_mem),
        .data_from_memory_io   (data_from_memory_io),
        .ram_en                (ram_en),
        .ram_we                (ram_we),
        .ram_addr              (ram_addr),
        .ram_wdata             (ram_wdata),
        .ram_rdata             (ram_rdata),
        .o_dbg_state           (dbg_state)
    );

    // BRAM model: filled with a fixed pattern on its first clock edge.
    logic [31:0] bram [256];
    logic [31:0] rd_pipe [L];
    logic        bram_filled = 1'b0;

    function automatic logic [31:0] fill_word(input int i);
        return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        if (!bram_filled) begin
            for (int i = 0; i < 256; i++) bram[i] <= fill_word(i);
            bram_filled <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) bram[ram_addr[7:0]] <= ram_wdata;
            rd_pipe[0] <= bram[ram_addr[7:0]];
        end
        for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign ram_rdata = rd_pipe[L-1];

    function automatic logic [31:0] gen_addr();
        logic [31:0] r;
        r = $urandom;
        return {r[31:19], 9'd0, r[7:0], r[9:8]};
    endfunction

    // Reference arbitration: eligible pendings, tie rule per build.
    function automatic logic model_pick();
        logic cp, ip;
        cp = (c_rd | c_wr) & core_start & ~core_end;
        ip = io_rd | io_wr;
        if (cp && ip) begin
`ifdef DMEM_ARB_RR_EN
            return (ref_last == WHO_IO) ? WHO_CORE : WHO_IO;
`else
            return WHO_IO;
`endif
        end
        return ip ? WHO_IO : WHO_CORE;
    endfunction

    // Entered at the start of the IDLE cycle in which 'who' is granted;
    // leaves at the start of the cycle after its ready, request dropped.
    task automatic serve_one(input logic who, input bit raise_end);
        logic        wr;
        logic [31:0] a, d;
        logic [16:0] exp_word;
        logic        exp_rm, exp_ri;
        int          lat;
        if (who == WHO_IO) begin
            wr = io_wr; a = io_addr; d = io_wdata;
        end else begin
            wr = c_wr; a = c_addr; d = c_wdata;
        end
        ref_last = who;
        exp_word = a[18:2];
        lat = wr ? 2 : L + 2;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b0 || data_ready_io !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: ram_en=%b data_ready_io=%b expected 0 0", ram_en, data_ready_io);
        end
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(posedge clk); #1;
            if (raise_end && cyc == 1) core_end = 1'b1;
            @(negedge clk);
            if (cyc == 1) begin
                checks++;
                if ({ram_en, ram_we, ram_addr} !== {1'b1, wr, exp_word}) begin
                    errors++;
                    $display("FAIL access: en/we/addr=%b/%b/%h expected 1/%b/%h (who=%0d)",
                             ram_en, ram_we, ram_addr, wr, exp_word, who);
                end
                if (wr) begin
                    checks++;
                    if (ram_wdata !== d) begin
                        errors++;
                        $display("FAIL wdata: got %h expected %h", ram_wdata, d);
                    end
                end
            end else begin
                checks++;
                if (ram_en !== 1'b0) begin
                    errors++;
                    $display("FAIL en_clear: cycle %0d ram_en=%b expected 0", cyc, ram_en);
                end
            end
            exp_rm = !(c_rd | c_wr) || (who == WHO_CORE && cyc == lat);
            exp_ri = (who == WHO_IO && cyc == lat);
            checks++;
            if (data_ready_mem !== exp_rm || data_ready_io !== exp_ri) begin
                errors++;
                $display("FAIL ready: cycle %0d mem/io=%b/%b expected %b/%b (who=%0d)",
                         cyc, data_ready_mem, data_ready_io, exp_rm, exp_ri, who);
            end
        end
        if (wr) ref_mem[a[9:2]] = d;
        else if (who == WHO_IO) ref_dio = ref_mem[a[9:2]];
        else ref_dm = ref_mem[a[9:2]];
        checks++;
        if (data_from_memory_mem !== ref_dm) begin
            errors++;
            $display("FAIL rdata_mem: got %h expected %h", data_from_memory_mem, ref_dm);
        end
        checks++;
        if (data_from_memory_io !== ref_dio) begin
            errors++;
            $display("FAIL rdata_io: got %h expected %h", data_from_memory_io, ref_dio);
        end
        @(posedge clk); #1;
        if (who == WHO_IO) begin
            io_rd = 1'b0; io_wr = 1'b0;
        end else begin
            c_rd = 1'b0; c_wr = 1'b0;
        end
    endtask

    task automatic serve_all();
        int guard;
        guard = 0;
        while (((c_rd | c_wr) || (io_rd | io_wr)) && guard < 3) begin
            serve_one(model_pick(), 1'b0);
            guard++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== '0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_port: en=%b we=%b addr=%h wdata=%h state=%0d expected all 0",
                     ram_en, ram_we, ram_addr, ram_wdata, dbg_state);
        end
        checks++;
        if (data_from_memory_mem !== '0 || data_from_memory_io !== '0) begin
            errors++;
            $display("FAIL reset_data: mem=%h io=%h expected 0", data_from_memory_mem, data_from_memory_io);
        end
        checks++;
        if (data_ready_mem !== 1'b1 || data_ready_io !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: mem=%b io=%b expected 1 0", data_ready_mem, data_ready_io);
        end
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        core_start = 1'b1;
    endtask

    task automatic test_tie();
        for (int r = 0; r < 2; r++) begin
            c_rd = 1'b1; c_addr = gen_addr();
            io_rd = 1'b1; io_addr = gen_addr();
            if (io_addr[9:2] == c_addr[9:2]) io_addr[9:2] = c_addr[9:2] + 8'd1;
            serve_all();
        end
    endtask

    task automatic test_io_write();
        io_wr = 1'b1; io_addr = 32'h20; io_wdata = 32'h1234_5678;
        serve_one(model_pick(), 1'b0);
    endtask

    task automatic test_core_read();
        io_wr = 1'b1; io_addr = 32'h10; io_wdata = 32'hDEAD_BEEF;
        serve_one(model_pick(), 1'b0);
        c_rd = 1'b1; c_addr = 32'h10;
        serve_one(model_pick(), 1'b0);
    endtask

    task automatic test_core_window();
        core_start = 1'b0;
        c_rd = 1'b1; c_addr = gen_addr();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ram_en !== 1'b0 || data_ready_mem !== 1'b0) begin
                errors++;
                $display("FAIL core_blocked: ram_en=%b ready_mem=%b expected 0 0", ram_en, data_ready_mem);
            end
            @(posedge clk); #1;
        end
        core_start = 1'b1;
        serve_one(model_pick(), 1'b0);
    endtask

    task automatic test_core_end();
        core_end = 1'b1;
        c_wr = 1'b1; c_addr = gen_addr(); c_wdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ram_en !== 1'b0 || data_ready_mem !== 1'b0) begin
                errors++;
                $display("FAIL core_end_block: ram_en=%b ready_mem=%b expected 0 0", ram_en, data_ready_mem);
            end
            @(posedge clk); #1;
        end
        core_end = 1'b0;
        c_wr = 1'b0; c_rd = 1'b1;
        serve_one(model_pick(), 1'b1);
        core_end = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            io_wr = 1'b1; io_addr = gen_addr(); io_wdata = $urandom;
            serve_one(model_pick(), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            c_rd = 1'b1; c_addr = gen_addr();
            serve_one(model_pick(), 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        c_rd = 1'b1; c_addr = gen_addr();
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_access: ram_en=%b expected 1", ram_en);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (dbg_state !== WAIT) begin
            errors++;
            $display("FAIL pre_reset_wait: state=%0d expected %0d", dbg_state, WAIT);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (ram_en !== 1'b0 || ram_addr !== '0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset: en=%b addr=%h state=%0d expected 0 0 0", ram_en, ram_addr, dbg_state);
        end
        checks++;
        if (data_from_memory_mem !== '0 || data_from_memory_io !== '0 ||
            data_ready_mem !== 1'b0 || data_ready_io !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out: dm=%h dio=%h rm=%b ri=%b expected 0 0 0 0",
                     data_from_memory_mem, data_from_memory_io, data_ready_mem, data_ready_io);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        ref_dm = '0; ref_dio = '0; ref_last = WHO_IO;
        serve_one(model_pick(), 1'b0);
    endtask

    task automatic test_random();
        int kc, ki;
        for (int it = 0; it < 40; it++) begin
            kc = $urandom_range(0, 3);
            ki = $urandom_range(0, 3);
            if (kc == 0 && ki == 0) ki = 1;
            c_rd = kc[0]; c_wr = kc[1]; c_addr = gen_addr(); c_wdata = $urandom;
            io_rd = ki[0]; io_wr = ki[1]; io_addr = gen_addr(); io_wdata = $urandom;
            serve_all();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = fill_word(i);
        test_reset();
        test_tie();
        test_io_write();
        test_core_read();
        test_core_window();
        test_core_end();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
